bitsync_lock_ctrl: RTL and testbench

Acquisition and lock controller for the bit synchronizer. It watches the recovered bit clock and the stretched early/late phase-detector pulses, then qualifies the loop over fixed windows of bit periods. It declares or drops lock and issues a one-cycle bit strobe to the downstream DQPSK symbol logic only while locked. It sits between the bit synchronizer outputs and the demodulator's sampling/deframing stage.

---
 rtl/bitsync_pkg.sv | 19 +
 rtl/bitsync_edge_det.sv | 16 +
 rtl/bitsync_lock_ctrl.sv | 123 ++++++++++++
 tb/tb_bitsync_lock_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bitsync_pkg.sv
// bitsync_pkg: shared state encodings and default loop-qualification constants
package bitsync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_LOCKED  = 3'd3
    } state_t;

    localparam int DEF_WIN_BITS     = 16;
    localparam int DEF_ACQ_MAX_ERR  = 4;
    localparam int DEF_LOCK_MAX_ERR = 2;
    localparam int DEF_LOCK_WINS    = 4;
    localparam int DEF_LOSS_WINS    = 2;
    localparam int DEF_TIMEOUT      = 128;
    localparam int DEF_ERR_W        = 8;

endpackage

// File: rtl/bitsync_edge_det.sv
// bitsync_edge_det: single-bit rising-edge detector with synchronous reset
module bitsync_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);

    logic d_q;

    // one-cycle history of the input; cleared on reset
    always_ff @(posedge clk) d_q <= rstn ? 1'b0 : d;

    assign rise = d & ~d_q;

endmodule

// File: rtl/bitsync_lock_ctrl.sv
// bitsync_lock_ctrl: window-based acquisition/lock qualifier for the bit synchronizer
module bitsync_lock_ctrl
    import bitsync_pkg::*;
#(
    parameter int WIN_BITS     = DEF_WIN_BITS,
    parameter int ACQ_MAX_ERR  = DEF_ACQ_MAX_ERR,
    parameter int LOCK_MAX_ERR = DEF_LOCK_MAX_ERR,
    parameter int LOCK_WINS    = DEF_LOCK_WINS,
    parameter int LOSS_WINS    = DEF_LOSS_WINS,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int ERR_W        = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             syn_in,
    input  logic             pd_before,
    input  logic             pd_after,
    output logic             lock,
    output logic             lock_lost,
    output logic             bit_strobe,
    output logic [2:0]       state,
    output logic [ERR_W-1:0] err_last
);

    localparam int BIT_W  = $clog2(WIN_BITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);
    localparam int BAD_W  = $clog2(LOSS_WINS + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t             state_q, state_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic [ERR_W-1:0]   err_cnt, err_n, err_total, err_last_n;
    logic [IDLE_W-1:0]  idle_cnt, idle_n;
    logic [GOOD_W-1:0]  good_cnt, good_n, good_inc;
    logic [BAD_W-1:0]   bad_cnt, bad_n, bad_inc;
    logic               tick, ev_before, ev_after, corr;
    logic               close, timeout, acq_ok, win_ok, lost_n;

    bitsync_edge_det u_syn (.clk(clk), .rstn(rstn), .d(syn_in),    .rise(tick));
    bitsync_edge_det u_bef (.clk(clk), .rstn(rstn), .d(pd_before), .rise(ev_before));
    bitsync_edge_det u_aft (.clk(clk), .rstn(rstn), .d(pd_after),  .rise(ev_after));

    assign corr      = ev_before | ev_after;
    assign err_total = (corr && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;
    assign close     = tick && bit_cnt == BIT_W'(WIN_BITS - 1);
    assign timeout   = !tick && idle_cnt == IDLE_W'(TIMEOUT - 1);
    assign acq_ok    = err_total <= ERR_W'(ACQ_MAX_ERR);
    assign win_ok    = err_total <= ERR_W'(LOCK_MAX_ERR);
    assign good_inc  = good_cnt + 1'b1;
    assign bad_inc   = bad_cnt + 1'b1;
    assign state     = state_q;

    // next-state, counter updates and lock-loss detection; counters default to cleared
    always_comb begin
        state_n    = state_q;
        bit_n      = '0;
        err_n      = '0;
        idle_n     = '0;
        good_n     = '0;
        bad_n      = '0;
        err_last_n = err_last;
        lost_n     = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_n = ST_ACQUIRE;
        end else if (timeout) begin
            state_n = ST_ACQUIRE;
            lost_n  = state_q == ST_LOCKED;
        end else begin
            idle_n = tick ? '0 : idle_cnt + 1'b1;
            bit_n  = close ? '0 : bit_cnt + BIT_W'(tick);
            err_n  = close ? '0 : err_total;
            good_n = good_cnt;
            bad_n  = bad_cnt;
            if (close) begin
                err_last_n = err_total;
                if (state_q == ST_ACQUIRE) begin
                    state_n = acq_ok ? ST_VERIFY : ST_ACQUIRE;
                    good_n  = acq_ok ? GOOD_W'(1) : '0;
                end else if (state_q == ST_VERIFY) begin
                    state_n = !win_ok ? ST_ACQUIRE :
                              (good_inc == GOOD_W'(LOCK_WINS)) ? ST_LOCKED : ST_VERIFY;
                    good_n  = (win_ok && good_inc != GOOD_W'(LOCK_WINS)) ? good_inc : '0;
                end else if (state_q == ST_LOCKED) begin
                    state_n = (!win_ok && bad_inc == BAD_W'(LOSS_WINS)) ? ST_ACQUIRE : ST_LOCKED;
                    bad_n   = (!win_ok && bad_inc != BAD_W'(LOSS_WINS)) ? bad_inc : '0;
                    lost_n  = !win_ok && bad_inc == BAD_W'(LOSS_WINS);
                end
            end
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= ST_IDLE;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            idle_cnt   <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            err_last   <= '0;
            lock       <= 1'b0;
            lock_lost  <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            state_q    <= state_n;
            bit_cnt    <= bit_n;
            err_cnt    <= err_n;
            idle_cnt   <= idle_n;
            good_cnt   <= good_n;
            bad_cnt    <= bad_n;
            err_last   <= err_last_n;
            lock       <= state_n == ST_LOCKED;
            lock_lost  <= lost_n;
            bit_strobe <= tick && state_q == ST_LOCKED;
        end
    end

endmodule

// File: tb/tb_bitsync_lock_ctrl.sv
// tb_bitsync_lock_ctrl: directed table-driven bench for the lock controller
module tb_bitsync_lock_ctrl;

    logic       clk = 1'b0;
    logic       rstn, enable, syn_in, pd_before, pd_after;
    logic       lock, lock_lost, bit_strobe;
    logic [2:0] state;
    logic [7:0] err_last;

    logic [2:0] post_st;
    logic       post_lk, post_sb, post_ll;
    logic [7:0] post_el;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;
    int lost_cnt = 0;
    int snap;

    typedef struct {
        int         nb;
        int         pd;
        logic [2:0] st;
        logic       lk;
        logic [7:0] el;
        logic       sb;
        logic       ll;
    } vec_t;

    vec_t vt [20];

    bitsync_lock_ctrl dut (
        .clk(clk), .rstn(rstn), .enable(enable), .syn_in(syn_in),
        .pd_before(pd_before), .pd_after(pd_after), .lock(lock),
        .lock_lost(lock_lost), .bit_strobe(bit_strobe), .state(state),
        .err_last(err_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bit_strobe === 1'b1) strobe_cnt++;
        if (lock_lost === 1'b1) lost_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one 32-cycle bit period; pd=1 adds a 4-cycle late pulse mid-period,
    // pd=2 raises both pd pulses together with the bit-clock edge
    task automatic bitp(input int pd);
        for (int c = 0; c < 32; c++) begin
            syn_in    = c < 16;
            pd_before = pd == 2 && c < 4;
            pd_after  = (pd == 1 && c >= 8 && c < 12) || (pd == 2 && c < 4);
            step(1);
            if (c == 0) begin
                post_st = state;
                post_lk = lock;
                post_el = err_last;
                post_sb = bit_strobe;
                post_ll = lock_lost;
            end
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            repeat (vt[i].nb) bitp(vt[i].pd);
            chk($sformatf("v%0d_state", i), post_st, vt[i].st);
            chk($sformatf("v%0d_lock", i), post_lk, vt[i].lk);
            chk($sformatf("v%0d_err_last", i), post_el, vt[i].el);
            chk($sformatf("v%0d_strobe", i), post_sb, vt[i].sb);
            chk($sformatf("v%0d_lost", i), post_ll, vt[i].ll);
        end
    endtask

    initial begin
        vt[0]  = '{15, 0, 3'd1, 1'b0, 8'd0,  1'b0, 1'b0};
        vt[1]  = '{1,  0, 3'd2, 1'b0, 8'd0,  1'b0, 1'b0};
        vt[2]  = '{47, 0, 3'd2, 1'b0, 8'd0,  1'b0, 1'b0};
        vt[3]  = '{1,  0, 3'd3, 1'b1, 8'd0,  1'b0, 1'b0};
        vt[4]  = '{1,  0, 3'd3, 1'b1, 8'd0,  1'b1, 1'b0};
        vt[5]  = '{3,  1, 3'd3, 1'b1, 8'd0,  1'b1, 1'b0};
        vt[6]  = '{12, 0, 3'd3, 1'b1, 8'd3,  1'b1, 1'b0};
        vt[7]  = '{3,  1, 3'd3, 1'b1, 8'd3,  1'b1, 1'b0};
        vt[8]  = '{13, 0, 3'd1, 1'b0, 8'd3,  1'b1, 1'b1};
        vt[9]  = '{63, 0, 3'd2, 1'b0, 8'd0,  1'b0, 1'b0};
        vt[10] = '{1,  0, 3'd3, 1'b1, 8'd0,  1'b0, 1'b0};
        vt[11] = '{63, 0, 3'd2, 1'b0, 8'd0,  1'b0, 1'b0};
        vt[12] = '{1,  0, 3'd3, 1'b1, 8'd0,  1'b0, 1'b0};
        vt[13] = '{15, 0, 3'd3, 1'b1, 8'd0,  1'b1, 1'b0};
        vt[14] = '{1,  2, 3'd3, 1'b1, 8'd1,  1'b1, 1'b0};
        vt[15] = '{16, 1, 3'd3, 1'b1, 8'd15, 1'b1, 1'b0};
        vt[16] = '{20, 0, 3'd2, 1'b0, 8'd0,  1'b0, 1'b0};
        vt[17] = '{63, 0, 3'd2, 1'b0, 8'd0,  1'b0, 1'b0};
        vt[18] = '{1,  0, 3'd3, 1'b1, 8'd0,  1'b0, 1'b0};
        vt[19] = '{1,  0, 3'd3, 1'b1, 8'd0,  1'b1, 1'b0};

        rstn = 1'b1; enable = 1'b0; syn_in = 1'b0; pd_before = 1'b0; pd_after = 1'b0;
        step(3);
        chk("rst_state", state, 0);
        chk("rst_lock", lock, 0);
        chk("rst_strobe", bit_strobe, 0);
        chk("rst_lost", lock_lost, 0);
        chk("rst_err_last", err_last, 0);
        rstn = 1'b0;
        step(2);
        chk("idle_hold", state, 0);
        enable = 1'b1;
        step(1);
        chk("idle_exit", state, 1);

        run(0, 8);
        chk("lost_once", lost_cnt, 1);

        run(9, 10);
        step(96);
        chk("to_before_state", state, 3);
        chk("to_before_lock", lock, 1);
        step(1);
        chk("to_state", state, 1);
        chk("to_lock", lock, 0);
        chk("to_lost", lock_lost, 1);
        step(1);
        chk("to_lost_clear", lock_lost, 0);
        chk("to_lost_cnt", lost_cnt, 2);

        run(11, 15);
        syn_in = 1'b1;
        rstn = 1'b1;
        step(1);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_lock", lock, 0);
        chk("mid_rst_strobe", bit_strobe, 0);
        chk("mid_rst_lost", lock_lost, 0);
        chk("mid_rst_err_last", err_last, 0);
        rstn = 1'b0;
        snap = strobe_cnt;
        for (int c = 1; c < 32; c++) begin
            syn_in = c < 16;
            step(1);
        end

        run(16, 16);
        snap = lost_cnt;
        enable = 1'b0;
        step(1);
        chk("dis_state", state, 0);
        chk("dis_lock", lock, 0);
        step(2);
        chk("dis_hold", state, 0);
        enable = 1'b1;
        step(1);
        chk("reen_state", state, 1);
        chk("dis_no_lost", lost_cnt, snap);

        snap = strobe_cnt;
        run(17, 18);
        chk("no_strobe_unlocked", strobe_cnt, snap);
        run(19, 19);
        chk("strobe_after_relock", strobe_cnt, snap + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
